// File: rtl/gp_dff_bank_arbiter_pkg.sv
// Shared types for the flop-bank arbiter: FSM state encoding, counter width, clog2 helper.
package gp_dff_bank_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WRITE = 2'd2,
        ST_COOL  = 2'd3
    } arb_state_t;

    localparam int CNT_W = 4;

    function automatic int gp_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gp_dff_bank_arbiter_dffr.sv
// Behavioural stand-in for the GreenPAK4 GP_DFFR cell: D flop with async active-low reset to 0.
module GP_DFFR (
    input  logic D,
    input  logic CLK,
    input  logic nRST,
    output logic Q
);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) Q <= 1'b0;
        else       Q <= D;
    end

endmodule

// File: rtl/gp_dff_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping NREQ-1 -> 0.
module gp_rr_pick
    import gp_dff_bank_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = gp_clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [PW-1:0]   idx,
    output logic            any
);

    // Walk offsets from farthest to nearest so the nearest match wins.
    always_comb begin
        int j;
        j      = 0;
        onehot = '0;
        idx    = '0;
        any    = |req;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (req[j]) idx = PW'(j);
        end
        if (any) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/gp_dff_bank_arbiter.sv
// Round-robin owner of a shared GP_DFFR holding bank: grant -> write -> cooldown.
// Optional grant watchdog enabled by defining GP_ARB_TIMEOUT_EN.
//
//  state    | meaning
//  ST_IDLE  | no owner; pick next requester from rr pointer
//  ST_GRANT | one requester owns the bank, waiting for its write strobe
//  ST_WRITE | bank just loaded; ack pulse, release grant
//  ST_COOL  | GAP-cycle quiet period, all requests ignored
module gp_dff_bank_arbiter
    import gp_dff_bank_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 8,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 7
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       wvalid,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic                  ack,
    output logic                  busy,
    output logic                  err,
    output logic [WIDTH-1:0]      q
);

    localparam int               PW        = gp_clog2(NREQ);
    localparam logic [CNT_W-1:0] COOL_LOAD = (GAP == 0) ? '0 : CNT_W'(GAP - 1);
    localparam arb_state_t       ST_DONE   = (GAP == 0) ? ST_IDLE : ST_COOL;
`ifdef GP_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] WD_LOAD   = CNT_W'(TIMEOUT - 1);
`endif

    arb_state_t       state, state_n;
    logic [PW-1:0]    ptr, win, ptr_adv, pick_idx;
    logic [NREQ-1:0]  pick_oh;
    logic             pick_any, load, drop, wd_fire, err_q, clr_b;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] bank_d;

    gp_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign ptr_adv = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
    assign load    = (state == ST_GRANT) && req[win] && wvalid[win];
    assign drop    = (state == ST_GRANT) && !req[win];

`ifdef GP_ARB_TIMEOUT_EN
    assign wd_fire = (state == ST_GRANT) && !load && !drop && (cnt == '0);
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= ST_IDLE;
            gnt   <= '0;
            ptr   <= '0;
            win   <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            err_q <= wd_fire;
            case (state)
                ST_IDLE: if (pick_any) begin
                    win <= pick_idx;
                    gnt <= pick_oh;
`ifdef GP_ARB_TIMEOUT_EN
                    cnt <= WD_LOAD;
`endif
                end
                ST_GRANT: if (drop || wd_fire) begin
                    // Abort advances the pointer too, so a flapping requester cannot starve others.
                    gnt <= '0;
                    ptr <= ptr_adv;
                    cnt <= COOL_LOAD;
                end
`ifdef GP_ARB_TIMEOUT_EN
                else if (!load) cnt <= cnt - 1'b1;
`endif
                ST_WRITE: begin
                    gnt <= '0;
                    ptr <= ptr_adv;
                    cnt <= COOL_LOAD;
                end
                ST_COOL: if (cnt != '0) cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (pick_any) state_n = ST_GRANT;
            ST_GRANT: begin
                if (load)                  state_n = ST_WRITE;
                else if (drop || wd_fire)  state_n = ST_DONE;
            end
            ST_WRITE: state_n = ST_DONE;
            ST_COOL:  if (cnt == '0) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        ack  = (state == ST_WRITE);
        busy = (state != ST_IDLE);
    end

    assign err = err_q;

    // Bank loads on the GRANT->WRITE edge so q is valid in the same cycle as ack.
    assign bank_d = load ? wdata[win*WIDTH +: WIDTH] : q;
    assign clr_b  = ~clr;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bank
        GP_DFFR u_ff (
            .D    (bank_d[i]),
            .CLK  (clk),
            .nRST (clr_b),
            .Q    (q[i])
        );
    end

endmodule
